// File: rtl/uge_sar_search.sv
// Successive-approximation search driving an external UGE comparator (GE = target >= TRIAL).
// Define SAR_SETTLE_EN to hold each trial one extra cycle for a registered comparator.
module uge_sar_search #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic         START,
  input  logic         GE,
  output logic [N-1:0] TRIAL,
  output logic [N-1:0] RESULT,
  output logic         BUSY,
  output logic         DONE
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TEST   = 2'd1,
`ifdef SAR_SETTLE_EN
    SETTLE = 2'd3,
`endif
    FIN    = 2'd2
  } state_t;

  // Every new trial goes through SETTLE when the comparator is pipelined.
`ifdef SAR_SETTLE_EN
  localparam state_t AFTER_TRIAL = SETTLE;
`else
  localparam state_t AFTER_TRIAL = TEST;
`endif

  state_t        state;
  logic [N-1:0]  acc;
  logic [BW-1:0] bit_idx;
  logic [N-1:0]  next_acc;
  logic [N-1:0]  next_bit;

  // A trial that the comparator accepts becomes part of the working value.
  assign next_acc = GE ? TRIAL : acc;
  assign next_bit = ONE << (bit_idx - BW'(1));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state   <= IDLE;
      acc     <= '0;
      bit_idx <= '0;
      TRIAL   <= '0;
      RESULT  <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            acc     <= '0;
            bit_idx <= BW'(N - 1);
            TRIAL   <= ONE << (N - 1);
            BUSY    <= 1'b1;
            state   <= AFTER_TRIAL;
          end
        end
`ifdef SAR_SETTLE_EN
        SETTLE: begin
          state <= TEST;
        end
`endif
        TEST: begin
          acc <= next_acc;
          if (bit_idx != '0) begin
            bit_idx <= bit_idx - BW'(1);
            TRIAL   <= next_acc | next_bit;
            state   <= AFTER_TRIAL;
          end else begin
            // TRIAL parks on the answer so IDLE presents RESULT.
            RESULT <= next_acc;
            TRIAL  <= next_acc;
            DONE   <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uge_sar_search.sv
// Directed self-checking bench for uge_sar_search (N=4) against a UGE comparator model.
// Follows SAR_SETTLE_EN: the comparator model becomes registered and trials last 2 cycles.
module tb_uge_sar_search;

  localparam int N = 4;
`ifdef SAR_SETTLE_EN
  localparam int HOLD = 2;
  localparam int EXP_B2B_DONES = 1;
`else
  localparam int HOLD = 1;
  localparam int EXP_B2B_DONES = 2;
`endif

  logic         CLK = 1'b0;
  logic         RESETN;
  logic         START;
  logic         GE;
  logic [N-1:0] TRIAL;
  logic [N-1:0] RESULT;
  logic         BUSY;
  logic         DONE;
  logic [N-1:0] target;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  // Comparator model: combinational, or one cycle late for the settle build.
`ifdef SAR_SETTLE_EN
  always @(posedge CLK) GE <= (target >= TRIAL);
`else
  assign GE = (target >= TRIAL);
`endif

  uge_sar_search #(.N(N)) dut (
    .CLK(CLK), .RESETN(RESETN), .START(START), .GE(GE),
    .TRIAL(TRIAL), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RESETN = 1'b0;
    START  = 1'b0;
    target = '0;
    #3;
    checks++;
    if ({TRIAL, RESULT, BUSY, DONE} !== '0) begin
      errors++;
      $display("FAIL reset_state: got trial=%0d result=%0d busy=%b done=%b expected all 0",
               TRIAL, RESULT, BUSY, DONE);
    end
    tick;
    tick;
    RESETN = 1'b1;
    tick;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", BUSY, DONE);
    end
  endtask

  // Single START pulse; checks each trial, DONE timing, RESULT and return to IDLE.
  task automatic test_search(input string name, input logic [N-1:0] tgt,
                             input logic [N-1:0] e0, input logic [N-1:0] e1,
                             input logic [N-1:0] e2, input logic [N-1:0] e3);
    logic [N-1:0] exp_seq [4];
    exp_seq[0] = e0; exp_seq[1] = e1; exp_seq[2] = e2; exp_seq[3] = e3;
    target = tgt;
    START  = 1'b1;
    tick;
    START  = 1'b0;
    for (int s = 0; s < N; s++) begin
      for (int h = 0; h < HOLD; h++) begin
        if (s != 0 || h != 0) tick;
        checks++;
        if (TRIAL !== exp_seq[s] || BUSY !== 1'b1 || DONE !== 1'b0) begin
          errors++;
          $display("FAIL %s trial step%0d.%0d: got trial=%0d busy=%b done=%b expected trial=%0d busy=1 done=0",
                   name, s, h, TRIAL, BUSY, DONE, exp_seq[s]);
        end
      end
    end
    tick;
    checks++;
    if (DONE !== 1'b1 || RESULT !== tgt || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL %s done_cycle: got done=%b result=%0d busy=%b expected done=1 result=%0d busy=1",
               name, DONE, RESULT, BUSY, tgt);
    end
    tick;
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || TRIAL !== tgt || RESULT !== tgt) begin
      errors++;
      $display("FAIL %s idle_after: got done=%b busy=%b trial=%0d result=%0d expected 0 0 %0d %0d",
               name, DONE, BUSY, TRIAL, RESULT, tgt, tgt);
    end
  endtask

  task automatic test_start_ignored;
    int elapsed;
    target = 4'd3;
    START  = 1'b1;
    tick;
    START  = 1'b0;
    tick;
    START  = 1'b1;
    tick;
    START  = 1'b0;
    elapsed = 2;
    while (DONE !== 1'b1 && elapsed < 20) begin
      tick;
      elapsed++;
    end
    checks++;
    if (elapsed != N * HOLD || RESULT !== 4'd3) begin
      errors++;
      $display("FAIL busy_start_done: got done_after=%0d result=%0d expected done_after=%0d result=3",
               elapsed, RESULT, N * HOLD);
    end
    START = 1'b1;
    tick;
    START = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL fin_start_ignored: got busy=%b done=%b expected 0 0", BUSY, DONE);
    end
    tick;
    checks++;
    if (BUSY !== 1'b0 || TRIAL !== 4'd3) begin
      errors++;
      $display("FAIL no_queued_search: got busy=%b trial=%0d expected busy=0 trial=3", BUSY, TRIAL);
    end
  endtask

  task automatic test_back_to_back;
    int dones;
    int first_at;
    int second_at;
    int waited;
    dones = 0; first_at = -1; second_at = -1;
    target = 4'd5;
    START  = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick;
      if (DONE === 1'b1) begin
        if (dones == 0) first_at = i;
        else if (dones == 1) second_at = i;
        dones++;
      end
    end
    START = 1'b0;
    checks++;
    if (dones != EXP_B2B_DONES || RESULT !== 4'd5) begin
      errors++;
      $display("FAIL b2b_count: got dones=%0d result=%0d expected dones=%0d result=5",
               dones, RESULT, EXP_B2B_DONES);
    end
    if (EXP_B2B_DONES == 2) begin
      checks++;
      if (second_at - first_at != N + 2 || first_at != N) begin
        errors++;
        $display("FAIL b2b_spacing: got first=%0d second=%0d expected first=%0d second=%0d",
                 first_at, second_at, N, 2 * N + 2);
      end
    end
    waited = 0;
    while (BUSY !== 1'b0 && waited < 40) begin
      tick;
      waited++;
    end
    checks++;
    if (BUSY !== 1'b0 || RESULT !== 4'd5) begin
      errors++;
      $display("FAIL b2b_drain: got busy=%b result=%0d expected busy=0 result=5", BUSY, RESULT);
    end
  endtask

  task automatic test_reset_mid_search;
    int stray;
    stray  = 0;
    target = 4'd9;
    START  = 1'b1;
    tick;
    START  = 1'b0;
    for (int i = 0; i < 2 * HOLD; i++) tick;
    RESETN = 1'b0;
    #1;
    checks++;
    if ({TRIAL, RESULT, BUSY, DONE} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got trial=%0d result=%0d busy=%b done=%b expected all 0",
               TRIAL, RESULT, BUSY, DONE);
    end
    tick;
    RESETN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (DONE !== 1'b0 || BUSY !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d cycles with done/busy set expected 0", stray);
    end
    test_search("t9_after_reset", 4'd9, 4'd8, 4'd12, 4'd10, 4'd9);
  endtask

  initial begin
    test_reset;
    test_search("t11", 4'd11, 4'd8, 4'd12, 4'd10, 4'd11);
    test_search("t0",  4'd0,  4'd8, 4'd4,  4'd2,  4'd1);
    test_search("t15", 4'd15, 4'd8, 4'd12, 4'd14, 4'd15);
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_search;
    test_search("t6",  4'd6,  4'd8, 4'd4,  4'd6,  4'd7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
